// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_t     : mdOp encodings (MD_NONE .. MD_MTLO, MD_RSVD)
//   - md_state_t  : unit FSM states (ST_IDLE, ST_RUN)
//   - MULT_CYCLES_DEF / DIV_CYCLES_DEF : default busy latencies
//   - is_arith()  : true for mult/multu/div/divu
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: multiply/divide unit in the EX stage, owner of the HI/LO registers.
// Executes mult/multu/div/divu with a fixed multi-cycle latency, serves
// mthi/mtlo writes and mfhi/mflo reads, and raises the pipeline freeze.
//
// Ports:
//   clk     in   1   pipeline clock, rising edge
//   reset   in   1   asynchronous, active-low; clears all state
//   start   in   1   EX-stage instruction is an md op (qualifies mdOp)
//   mdOp    in   3   operation code, see md_pkg::md_op_t
//   A       in  32   rs operand (forwarded)
//   B       in  32   rt operand (forwarded)
//   readHi  in   1   1: mdOut = HI, 0: mdOut = LO
//   useMd   in   1   EX-stage instruction touches HI/LO
//   busy    out  1   arithmetic operation in flight
//   freeze  out  1   stall request to pipeline registers and PC
//   mdOut   out 32   HI or LO, straight from the registers
module md_unit
   import md_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  mdOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        readHi,
   input  logic        useMd,
   output logic        busy,
   output logic        freeze,
   output logic [31:0] mdOut
);

   md_state_t   state_reg;
   logic [3:0]  count_reg;
   logic [31:0] hi_reg;
   logic [31:0] lo_reg;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   md_op_t      op_reg;

   md_op_t      op_in;
   logic        arith_issue;

   // datapath results computed from the latched operands
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] product;
   logic        div_signed;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] divisor;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quotient;
   logic [31:0] remainder;

   assign op_in       = md_op_t'(mdOp);
   assign arith_issue = start & is_arith(mdOp);

   // One 64x64 multiplier serves both mult and multu: sign- or zero-extending
   // the operands to 64 bits makes the low 64 bits of the product correct for
   // either interpretation.
   always_comb begin
      ext_a   = (op_reg == MD_MULT) ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
      ext_b   = (op_reg == MD_MULT) ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
      product = ext_a * ext_b;
   end

   // Signed division is done on magnitudes, then the signs are restored:
   // quotient truncates toward zero, remainder follows the dividend. The
   // divisor is forced non-zero so the divider never sees x/0; the commit
   // logic discards the result in that case anyway.
   always_comb begin
      div_signed = (op_reg == MD_DIV);
      a_neg      = div_signed & a_reg[31];
      b_neg      = div_signed & b_reg[31];
      mag_a      = a_neg ? (32'd0 - a_reg) : a_reg;
      mag_b      = b_neg ? (32'd0 - b_reg) : b_reg;
      divisor    = (mag_b == 32'd0) ? 32'd1 : mag_b;
      q_mag      = mag_a / divisor;
      r_mag      = mag_a % divisor;
      quotient   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      remainder  = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         count_reg <= 4'd0;
         hi_reg    <= 32'd0;
         lo_reg    <= 32'd0;
         a_reg     <= 32'd0;
         b_reg     <= 32'd0;
         op_reg    <= MD_NONE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  case (op_in)
                     MD_MULT, MD_MULTU: begin
                        a_reg     <= A;
                        b_reg     <= B;
                        op_reg    <= op_in;
                        count_reg <= 4'(MULT_CYCLES);
                        state_reg <= ST_RUN;
                     end
                     MD_DIV, MD_DIVU: begin
                        a_reg     <= A;
                        b_reg     <= B;
                        op_reg    <= op_in;
                        count_reg <= 4'(DIV_CYCLES);
                        state_reg <= ST_RUN;
                     end
                     MD_MTHI: hi_reg <= A;
                     MD_MTLO: lo_reg <= A;
                     default: ;
                  endcase
               end
            end
            ST_RUN: begin
               // start is deliberately not looked at here: a second op
               // presented while running must not disturb the latched one.
               if (count_reg == 4'd1) begin
                  count_reg <= 4'd0;
                  state_reg <= ST_IDLE;
                  if ((op_reg == MD_MULT) || (op_reg == MD_MULTU)) begin
                     hi_reg <= product[63:32];
                     lo_reg <= product[31:0];
                  end else if (b_reg != 32'd0) begin
                     hi_reg <= remainder;
                     lo_reg <= quotient;
                  end
               end else begin
                  count_reg <= count_reg - 4'd1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
               count_reg <= 4'd0;
            end
         endcase
      end
   end

   assign busy = (state_reg == ST_RUN);

   // The issuing mult/div freezes itself in EX for its issue cycle so the
   // next instruction, if it touches HI/LO, waits for the result.
   assign freeze = useMd & (busy | arith_issue);

   assign mdOut = readHi ? hi_reg : lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. Stimulus tasks push expected
// mfhi/mflo values and expected busy-run lengths into queues; a monitor
// process pops and compares whenever the DUT accepts a read (useMd, no
// start, no freeze) or ends a busy run.
module tb_md_unit;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  mdOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        readHi;
   logic        useMd;
   logic        busy;
   logic        freeze;
   logic [31:0] mdOut;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic [31:0] value;
   } rd_exp_t;

   rd_exp_t rd_q[$];
   int      busy_q[$];
   int      busy_run = 0;

   md_unit dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .mdOp   (mdOp),
      .A      (A),
      .B      (B),
      .readHi (readHi),
      .useMd  (useMd),
      .busy   (busy),
      .freeze (freeze),
      .mdOut  (mdOut)
   );

   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      total++;
      bad++;
      $display("FAIL %s: %s", name, what);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      rd_exp_t e;
      int      exp_len;
      forever begin
         @(negedge clk);
         if (!reset) begin
            busy_run = 0;   // aborted operation: no result expected
         end else begin
            if (busy) begin
               busy_run++;
            end else if (busy_run != 0) begin
               if (busy_q.size() == 0) begin
                  fail_now("busy_len", $sformatf("unexpected busy run of %0d", busy_run));
               end else begin
                  exp_len = busy_q.pop_front();
                  check32("busy_len", 32'(busy_run), 32'(exp_len));
               end
               busy_run = 0;
            end
            if (useMd && !start && !freeze) begin
               if (rd_q.size() == 0) begin
                  fail_now("read", $sformatf("unexpected read mdOut=%h", mdOut));
               end else begin
                  e = rd_q.pop_front();
                  check32(e.name, mdOut, e.value);
               end
            end
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   // All tasks start and end at #1 after a rising edge.
   task automatic idle_inputs();
      start = 1'b0;
      mdOp  = 3'd0;
      useMd = 1'b0;
      A     = 32'd0;
      B     = 32'd0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy);
      int guard = 0;
      start = 1'b1;
      mdOp  = op;
      useMd = 1'b1;
      A     = a;
      B     = b;
      while (busy && guard < 50) begin
         tick(1);
         guard++;
      end
      if (guard >= 50) fail_now("issue_wait", "busy never dropped");
      if (exp_busy > 0) busy_q.push_back(exp_busy);
      tick(1);
      idle_inputs();
   endtask

   task automatic read(input logic hi, input string name, input logic [31:0] exp,
                       output int frozen);
      start  = 1'b0;
      mdOp   = 3'd0;
      useMd  = 1'b1;
      readHi = hi;
      rd_q.push_back('{name, exp});
      frozen = 0;
      forever begin
         @(negedge clk);
         if (!freeze) break;
         frozen++;
         if (frozen > 50) begin
            fail_now(name, "freeze never dropped");
            void'(rd_q.pop_back());
            break;
         end
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic mt(input logic hi, input logic [31:0] val);
      start = 1'b1;
      mdOp  = hi ? MD_MTHI : MD_MTLO;
      useMd = 1'b1;
      A     = val;
      tick(1);
      idle_inputs();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int fz;
      reset  = 1'b0;
      readHi = 1'b0;
      idle_inputs();
      tick(2);
      check32("rst_busy", 32'(busy), 32'd0);
      check32("rst_freeze", 32'(freeze), 32'd0);
      check32("rst_lo", mdOut, 32'd0);
      readHi = 1'b1;
      #1;
      check32("rst_hi", mdOut, 32'd0);
      tick(1);
      reset = 1'b1;
      tick(1);

      // mult -3 * 5, mfhi presented right behind it
      issue(MD_MULT, 32'hFFFF_FFFD, 32'd5, 5);
      read(1'b1, "mult_hi", 32'hFFFF_FFFF, fz);
      check32("mult_freeze_cycles", 32'(fz), 32'd5);
      read(1'b0, "mult_lo", 32'hFFFF_FFF1, fz);

      // multu with a non-md instruction behind it: no freeze
      issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5);
      @(negedge clk);
      check32("nonmd_freeze", 32'(freeze), 32'd0);
      check32("nonmd_busy", 32'(busy), 32'd1);
      tick(1);
      read(1'b1, "multu_hi", 32'h0000_0001, fz);
      read(1'b0, "multu_lo", 32'hFFFF_FFFE, fz);

      // mtlo / mthi then immediate read
      mt(1'b0, 32'h1234_5678);
      read(1'b0, "mtlo_mflo", 32'h1234_5678, fz);
      check32("mt_freeze_cycles", 32'(fz), 32'd0);
      mt(1'b1, 32'hCAFE_BABE);
      read(1'b1, "mthi_mfhi", 32'hCAFE_BABE, fz);

      // div -7 / 2
      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
      read(1'b0, "div_lo", 32'hFFFF_FFFD, fz);
      check32("div_freeze_cycles", 32'(fz), 32'd10);
      read(1'b1, "div_hi", 32'hFFFF_FFFF, fz);

      // divu by zero leaves HI/LO alone
      mt(1'b1, 32'h0BAD_F00D);
      mt(1'b0, 32'h00C0_FFEE);
      issue(MD_DIVU, 32'd7, 32'd0, 10);
      read(1'b1, "divz_hi", 32'h0BAD_F00D, fz);
      read(1'b0, "divz_lo", 32'h00C0_FFEE, fz);

      // new mult presented while busy must be ignored
      issue(MD_MULT, 32'd3, 32'd4, 5);
      start = 1'b1;
      mdOp  = MD_MULT;
      A     = 32'd100;
      B     = 32'd100;
      useMd = 1'b0;
      tick(2);
      idle_inputs();
      read(1'b0, "ignore_lo", 32'd12, fz);
      read(1'b1, "ignore_hi", 32'd0, fz);

      // reset during a div in busy cycle 4
      mt(1'b1, 32'h0000_0055);
      mt(1'b0, 32'h0000_00AA);
      issue(MD_DIV, 32'd100, 32'd7, 0);
      tick(3);
      reset = 1'b0;
      #1;
      check32("abort_busy", 32'(busy), 32'd0);
      readHi = 1'b1;
      #1;
      check32("abort_hi", mdOut, 32'd0);
      readHi = 1'b0;
      #1;
      check32("abort_lo", mdOut, 32'd0);
      tick(1);
      reset = 1'b1;
      tick(12);
      check32("post_abort_busy", 32'(busy), 32'd0);
      read(1'b1, "post_abort_hi", 32'd0, fz);
      read(1'b0, "post_abort_lo", 32'd0, fz);

      tick(2);
      check32("busy_q_empty", 32'(busy_q.size()), 32'd0);
      check32("rd_q_empty", 32'(rd_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
